int_ctrl: RTL and testbench

//  Interrupt controller on the target side of the CPU's interrupt request/acknowledge handshake.
//  - Collects NSRC external interrupt lines and latches their rising edges as pending bits.
//  - Prioritises the pending, unmasked sources and drives Intr to the CPU.
//  - On Inta from the CPU, latches the winning vector.
//  - Exposes PEND/MASK/VEC/EOI as a memory-mapped slave on the CPU data bus.
//  - Supplies the cause word that the CPU loads into its Cause register.

---
 rtl/int_ctrl.sv | 78 +++++++
 tb/tb_int_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: edge-latching, fixed-priority interrupt controller with a memory-mapped PEND/MASK/VEC/EOI window
module int_ctrl #(
  parameter int          NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic [NSRC-1:0] Irq,
  output logic            Intr,
  input  logic            Inta,
  input  logic            Eret,
  input  logic [31:0]     Daddr,
  input  logic [31:0]     Dwrite,
  input  logic            Wmem,
  output logic            Hit,
  output logic [31:0]     Rdata,
  output logic [31:0]     IntCause
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t            r_state, w_next;
  logic [NSRC-1:0]   r_s1, r_s2, r_prev, r_pend, r_mask;
  logic [2:0]        r_vec, w_win;
  logic [NSRC-1:0]   w_rise, w_ip, w_w1c, w_win_oh;
  logic [1:0]        w_off;
  logic              w_any, w_wr, w_eoi, w_take, w_serv;
  logic              w_unused;
  assign w_unused = ^{Daddr[1:0], Dwrite[31:NSRC]};
  assign w_rise   = r_s2 & ~r_prev;
  assign w_ip     = r_pend & r_mask;
  assign w_any    = |w_ip;
  assign w_off    = Daddr[3:2];
  assign Hit      = Daddr[31:4] == BASE_ADDR[31:4];
  assign w_wr     = Hit & Wmem;
  assign w_eoi    = w_wr && w_off == 2'd3;
  assign w_w1c    = (w_wr && w_off == 2'd0) ? Dwrite[NSRC-1:0] : '0;
  assign w_take   = r_state == REQ && Inta && w_any;
  assign w_win_oh = w_take ? NSRC'(1) << w_win : '0;
  assign w_serv   = r_state == SERV;
  assign Intr     = r_state == REQ;
  assign IntCause = {16'b0, 8'(w_ip), 8'b0};
  assign Rdata    = !Hit ? 32'b0 :
                    w_off == 2'd0 ? 32'(r_pend) :
                    w_off == 2'd1 ? 32'(r_mask) :
                    w_off == 2'd2 ? {w_serv, 28'b0, r_vec} : 32'b0;
  // lowest set index wins, so scan from the top down
  always_comb begin
    w_win = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (w_ip[i]) w_win = 3'(i);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? REQ : IDLE;
      REQ:     w_next = w_take ? SERV : !w_any ? IDLE : REQ;
      SERV:    w_next = (Eret || w_eoi) ? IDLE : SERV;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_next;
      r_s1    <= Irq;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_pend  <= (r_pend & ~w_w1c & ~w_win_oh) | w_rise;
      if (w_wr && w_off == 2'd1) r_mask <= Dwrite[NSRC-1:0];
      if (w_take) r_vec <= w_win;
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vectors with hand-computed expectations for int_ctrl
module tb_int_ctrl;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_PEND = BASE, A_MASK = BASE + 4, A_VEC = BASE + 8, A_EOI = BASE + 12;
  logic        Clk = 0, Clr = 1, Intr, Inta = 0, Eret = 0, Wmem = 0, Hit;
  logic [7:0]  Irq = 0;
  logic [31:0] Daddr = 0, Dwrite = 0, Rdata, IntCause;
  int n_cmp = 0, n_err = 0;
  int_ctrl #(.NSRC(8), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Clr(Clr), .Irq(Irq), .Intr(Intr), .Inta(Inta), .Eret(Eret),
    .Daddr(Daddr), .Dwrite(Dwrite), .Wmem(Wmem), .Hit(Hit), .Rdata(Rdata), .IntCause(IntCause)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Daddr = a; Dwrite = d; Wmem = 1;
    tick();
    Wmem = 0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Daddr = a;
    #1;
    chk(tag, Rdata, exp);
  endtask
  task automatic pulse_inta();
    Inta = 1; tick(); Inta = 0;
  endtask
  task automatic pulse_eret();
    Eret = 1; tick(); Eret = 0;
  endtask
  initial begin
    tick(3);
    chk("reset_intr", {31'b0, Intr}, 0);
    rd("reset_pend", A_PEND, 0);
    rd("reset_vec", A_VEC, 0);
    Clr = 0;
    tick();
    // 1: single source, latency and acknowledge
    wr(A_MASK, 32'h01);
    Irq = 8'h01;
    tick(3);
    rd("t1_pend3", A_PEND, 32'h01);
    chk("t1_intr3", {31'b0, Intr}, 0);
    tick();
    chk("t1_intr4", {31'b0, Intr}, 1);
    pulse_inta();
    chk("t1_intr_ack", {31'b0, Intr}, 0);
    rd("t1_vec", A_VEC, 32'h8000_0000);
    rd("t1_pend_ack", A_PEND, 0);
    pulse_eret();
    rd("t1_vec_eret", A_VEC, 0);
    // 2: two simultaneous sources, priority and cause word
    wr(A_MASK, 32'hFF);
    Irq = 8'h25;
    tick(3);
    chk("t2_cause", IntCause, 32'h0000_2400);
    tick();
    chk("t2_intr", {31'b0, Intr}, 1);
    pulse_inta();
    rd("t2_vec2", A_VEC, 32'h8000_0002);
    rd("t2_pend", A_PEND, 32'h20);
    pulse_eret();
    chk("t2_intr_idle", {31'b0, Intr}, 0);
    tick();
    chk("t2_intr_rerise", {31'b0, Intr}, 1);
    pulse_inta();
    rd("t2_vec5", A_VEC, 32'h8000_0005);
    pulse_eret();
    // 3: masking holds off and withdraws a request
    wr(A_MASK, 32'h00);
    Irq = 8'h2D;
    tick(3);
    rd("t3_pend", A_PEND, 32'h08);
    tick();
    chk("t3_intr_masked", {31'b0, Intr}, 0);
    wr(A_MASK, 32'h08);
    chk("t3_intr_1clk", {31'b0, Intr}, 0);
    tick();
    chk("t3_intr_2clk", {31'b0, Intr}, 1);
    wr(A_MASK, 32'h00);
    tick();
    chk("t3_intr_withdrawn", {31'b0, Intr}, 0);
    pulse_inta();
    rd("t3_vec_kept", A_VEC, 32'h0000_0005);
    wr(A_PEND, 32'h08);
    rd("t3_pend_w1c", A_PEND, 0);
    // 4: edge versus W1C collision, and level held high
    Irq = 8'h2F;
    tick(2);
    wr(A_PEND, 32'h02);
    rd("t4_set_wins", A_PEND, 32'h02);
    wr(A_PEND, 32'h02);
    rd("t4_w1c", A_PEND, 0);
    tick(100);
    rd("t4_level_once", A_PEND, 0);
    // 5: EOI write ends service, stray eret, out-of-window access
    wr(A_MASK, 32'h10);
    Irq = 8'h3F;
    tick(4);
    chk("t5_intr", {31'b0, Intr}, 1);
    pulse_inta();
    rd("t5_vec_serv", A_VEC, 32'h8000_0004);
    wr(A_EOI, 32'h0);
    rd("t5_vec_eoi", A_VEC, 32'h0000_0004);
    pulse_eret();
    rd("t5_vec_eret_idle", A_VEC, 32'h0000_0004);
    chk("t5_intr_idle", {31'b0, Intr}, 0);
    rd("t5_eoi_read", A_EOI, 0);
    chk("t5_hit_in", {31'b0, Hit}, 1);
    rd("t5_rdata_out", BASE + 32'h10, 0);
    chk("t5_hit_out", {31'b0, Hit}, 0);
    // 6: asynchronous reset mid-request
    wr(A_MASK, 32'h40);
    Irq = 8'h7F;
    tick(4);
    chk("t6_intr_req", {31'b0, Intr}, 1);
    #1 Clr = 1;
    #1 chk("t6_intr_clr", {31'b0, Intr}, 0);
    rd("t6_pend_clr", A_PEND, 0);
    rd("t6_mask_clr", A_MASK, 0);
    Clr = 0;
    tick(10);
    chk("t6_no_req", {31'b0, Intr}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
